// File: rtl/priority_encoder_scan_display.sv
// ============================================================================
// Module   : priority_encoder_scan_display
// Brief    : Synchronised highest-index priority encoder with popcount,
//            scanned onto four digits of an 8-digit seven-segment display.
// Revision : 1.0
// ============================================================================
`default_nettype none

module priority_encoder_scan_display #(
    parameter int N     = 16,
    parameter int CNT_W = 18,
    localparam int IW   = (N < 2) ? 1 : $clog2(N),
    localparam int PW   = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  w,
    input  logic          hold,
    output logic [IW-1:0] y,
    output logic          z,
    output logic [PW-1:0] cnt,
    output logic [6:0]    sseg,
    output logic [7:0]    AN,
    output logic          DP
);

    localparam logic [6:0] C_DASH  = 7'b0111111;
    localparam logic [6:0] C_BLANK = 7'h7F;

    logic [N-1:0]     r_s1, r_s2;
    logic [IW-1:0]    r_y;
    logic             r_z;
    logic [PW-1:0]    r_cnt;
    logic [CNT_W-1:0] r_scan;
    logic [7:0]       r_an;
    logic [6:0]       r_sseg;

    logic [IW-1:0]    w_y;
    logic [PW-1:0]    w_cnt;
    logic [1:0]       w_digit;
    logic [7:0]       w_y8, w_c8;
    logic [3:0]       w_nib;
    logic             w_dash;
    logic [7:0]       w_an;
    logic [6:0]       w_sseg;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Ascending scan: the last set bit seen is the highest-priority one.
    always_comb begin
        w_y   = '0;
        w_cnt = '0;
        for (int i = 0; i < N; i++) begin
            if (r_s2[i]) begin
                w_y = IW'(i);
            end
            w_cnt = w_cnt + PW'(r_s2[i]);
        end
    end

    always_comb begin
        w_digit          = r_scan[CNT_W-1 -: 2];
        w_y8             = '0;
        w_y8[IW-1:0]     = r_y;
        w_c8             = '0;
        w_c8[PW-1:0]     = r_cnt;
        w_an             = 8'hFF;
        w_nib            = 4'h0;
        w_dash           = 1'b0;
        case (w_digit)
            2'd0: begin w_an = 8'hFE; w_nib = w_y8[3:0]; w_dash = ~r_z; end
            2'd1: begin w_an = 8'hFD; w_nib = w_y8[7:4]; w_dash = ~r_z; end
            2'd2: begin w_an = 8'hFB; w_nib = w_c8[3:0]; end
            default: begin w_an = 8'hF7; w_nib = w_c8[7:4]; end
        endcase
        w_sseg = w_dash ? C_DASH : hex7(w_nib);
    end

    // Anode and segment registers share an edge so the two never disagree.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_y    <= '0;
            r_z    <= 1'b0;
            r_cnt  <= '0;
            r_scan <= '0;
            r_an   <= 8'hFF;
            r_sseg <= C_BLANK;
        end else begin
            r_s1 <= w;
            r_s2 <= r_s1;
            if (!hold) begin
                r_y   <= w_y;
                r_z   <= |r_s2;
                r_cnt <= w_cnt;
            end
            r_scan <= r_scan + CNT_W'(1);
            r_an   <= w_an;
            r_sseg <= w_sseg;
        end
    end

    assign y    = r_y;
    assign z    = r_z;
    assign cnt  = r_cnt;
    assign sseg = r_sseg;
    assign AN   = r_an;
    assign DP   = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_priority_encoder_scan_display.sv
// ============================================================================
// Module   : tb_priority_encoder_scan_display
// Brief    : Scoreboard bench for priority_encoder_scan_display (N=16 and N=64).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_priority_encoder_scan_display;

    typedef struct {
        logic [5:0] y;
        logic       z;
        logic [6:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic [15:0] w16;
    logic [63:0] w64;
    logic [3:0]  y16;
    logic        z16;
    logic [4:0]  cnt16;
    logic [6:0]  sseg16;
    logic [7:0]  an16;
    logic        dp16;
    logic [5:0]  y64;
    logic        z64;
    logic [6:0]  cnt64;
    logic [6:0]  sseg64;
    logic [7:0]  an64;
    logic        dp64;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    priority_encoder_scan_display #(.N(16), .CNT_W(4)) dut16 (
        .clk(clk), .reset(reset), .w(w16), .hold(hold),
        .y(y16), .z(z16), .cnt(cnt16), .sseg(sseg16), .AN(an16), .DP(dp16)
    );

    priority_encoder_scan_display #(.N(64), .CNT_W(4)) dut64 (
        .clk(clk), .reset(reset), .w(w64), .hold(1'b0),
        .y(y64), .z(z64), .cnt(cnt64), .sseg(sseg64), .AN(an64), .DP(dp64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        tick(); tick();
        n_tests++;
        if ({an16, sseg16, dp16} !== {8'hFF, 7'h7F, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_display: got AN=%h sseg=%h DP=%b, want AN=ff sseg=7f DP=1", an16, sseg16, dp16);
        end
        n_tests++;
        if ({y16, z16, cnt16} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_result: got y=%0d z=%0d cnt=%0d, want 0 0 0", y16, z16, cnt16);
        end
        reset = 1'b0;
        sb.push_back('{y: 6'd15, z: 1'b1, cnt: 7'd16});
        tick(); tick();
        n_tests++;
        if (z16 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_latency: z=%0d after 2 clocks, want 0", z16);
        end
        tick();
        e = sb.pop_front();
        n_tests++;
        if ({y16, z16, cnt16} !== {e.y[3:0], e.z, e.cnt[4:0]}) begin
            n_fail++;
            $display("FAIL reset_release: got y=%0d z=%0d cnt=%0d, want y=%0d z=%0d cnt=%0d", y16, z16, cnt16, e.y, e.z, e.cnt);
        end
    endtask

    task automatic test_encode();
        exp_t e;
        w16 = 16'h0028;
        sb.push_back('{y: 6'd5, z: 1'b1, cnt: 7'd2});
        tick(); tick();
        n_tests++;
        if (y16 !== 4'd15) begin
            n_fail++;
            $display("FAIL encode_latency: y=%0d after 2 clocks, want 15", y16);
        end
        tick();
        e = sb.pop_front();
        n_tests++;
        if ({y16, z16, cnt16} !== {e.y[3:0], e.z, e.cnt[4:0]}) begin
            n_fail++;
            $display("FAIL encode: got y=%0d z=%0d cnt=%0d, want y=%0d z=%0d cnt=%0d", y16, z16, cnt16, e.y, e.z, e.cnt);
        end
    endtask

    task automatic test_display(input string tag, input bit sel,
                                input logic [6:0] e0, input logic [6:0] e1,
                                input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] ex[4];
        bit         seen[4];
        logic [7:0] an;
        logic [6:0] ss;
        int         d;
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        for (int k = 0; k < 4; k++) seen[k] = 1'b0;
        tick(); tick();
        for (int c = 0; c < 16; c++) begin
            an = sel ? an64 : an16;
            ss = sel ? sseg64 : sseg16;
            case (an)
                8'hFE: d = 0;
                8'hFD: d = 1;
                8'hFB: d = 2;
                8'hF7: d = 3;
                default: d = -1;
            endcase
            n_tests++;
            if (d < 0) begin
                n_fail++;
                $display("FAIL %s_anode: AN=%h, want exactly one of AN[3:0] low", tag, an);
            end else begin
                seen[d] = 1'b1;
                n_tests++;
                if (ss !== ex[d]) begin
                    n_fail++;
                    $display("FAIL %s_digit%0d: sseg=%h, want %h", tag, d, ss, ex[d]);
                end
            end
            tick();
        end
        n_tests++;
        if (!(seen[0] && seen[1] && seen[2] && seen[3])) begin
            n_fail++;
            $display("FAIL %s_scan: digits seen %b%b%b%b, want 1111", tag, seen[3], seen[2], seen[1], seen[0]);
        end
    endtask

    task automatic test_zero();
        exp_t e;
        w16 = 16'h0000;
        sb.push_back('{y: 6'd0, z: 1'b0, cnt: 7'd0});
        tick(); tick(); tick();
        e = sb.pop_front();
        n_tests++;
        if ({y16, z16, cnt16} !== {e.y[3:0], e.z, e.cnt[4:0]}) begin
            n_fail++;
            $display("FAIL zero: got y=%0d z=%0d cnt=%0d, want y=%0d z=%0d cnt=%0d", y16, z16, cnt16, e.y, e.z, e.cnt);
        end
    endtask

    task automatic test_hold();
        exp_t e;
        w16 = 16'h8000;
        sb.push_back('{y: 6'd15, z: 1'b1, cnt: 7'd1});
        tick(); tick(); tick();
        e = sb.pop_front();
        n_tests++;
        if ({y16, z16, cnt16} !== {e.y[3:0], e.z, e.cnt[4:0]}) begin
            n_fail++;
            $display("FAIL hold_capture: got y=%0d z=%0d cnt=%0d, want y=%0d z=%0d cnt=%0d", y16, z16, cnt16, e.y, e.z, e.cnt);
        end
        hold = 1'b1;
        w16  = 16'h0001;
        repeat (5) tick();
        n_tests++;
        if ({y16, z16, cnt16} !== {4'd15, 1'b1, 5'd1}) begin
            n_fail++;
            $display("FAIL hold_freeze: got y=%0d z=%0d cnt=%0d, want y=15 z=1 cnt=1", y16, z16, cnt16);
        end
        hold = 1'b0;
        sb.push_back('{y: 6'd0, z: 1'b1, cnt: 7'd1});
        tick();
        e = sb.pop_front();
        n_tests++;
        if ({y16, z16, cnt16} !== {e.y[3:0], e.z, e.cnt[4:0]}) begin
            n_fail++;
            $display("FAIL hold_release: got y=%0d z=%0d cnt=%0d, want y=%0d z=%0d cnt=%0d", y16, z16, cnt16, e.y, e.z, e.cnt);
        end
        hold  = 1'b1;
        reset = 1'b1;
        tick();
        n_tests++;
        if ({y16, z16, cnt16} !== 10'd0) begin
            n_fail++;
            $display("FAIL hold_vs_reset: got y=%0d z=%0d cnt=%0d, want 0 0 0", y16, z16, cnt16);
        end
        reset = 1'b0;
        hold  = 1'b0;
    endtask

    task automatic test_n64();
        exp_t e;
        w64 = '1;
        sb.push_back('{y: 6'd63, z: 1'b1, cnt: 7'd64});
        tick(); tick(); tick();
        e = sb.pop_front();
        n_tests++;
        if ({y64, z64, cnt64} !== {e.y, e.z, e.cnt}) begin
            n_fail++;
            $display("FAIL n64: got y=%0d z=%0d cnt=%0d, want y=%0d z=%0d cnt=%0d", y64, z64, cnt64, e.y, e.z, e.cnt);
        end
    endtask

    task automatic test_reset_midscan();
        logic [7:0] prev;
        bit         found = 1'b0;
        for (int c = 0; c < 64 && !found; c++) begin
            prev = an16;
            tick();
            if (prev == 8'hFD && an16 == 8'hFB) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL midscan_find: AN never stepped FD->FB within 64 clocks, last AN=%h", an16);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if ({an16, sseg16} !== {8'hFF, 7'h7F}) begin
            n_fail++;
            $display("FAIL midscan_blank: got AN=%h sseg=%h, want AN=ff sseg=7f", an16, sseg16);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_tests++;
            if (an16 !== 8'hFE) begin
                n_fail++;
                $display("FAIL midscan_digit0_%0d: AN=%h, want fe", c, an16);
            end
        end
        tick();
        n_tests++;
        if (an16 !== 8'hFD) begin
            n_fail++;
            $display("FAIL midscan_digit1: AN=%h, want fd", an16);
        end
    endtask

    initial begin
        reset = 1'b1;
        hold  = 1'b0;
        w16   = 16'hFFFF;
        w64   = '0;
        test_reset();
        test_encode();
        test_display("enc", 1'b0, 7'h12, 7'h40, 7'h24, 7'h40);
        test_zero();
        test_display("zero", 1'b0, 7'h3F, 7'h3F, 7'h40, 7'h40);
        test_hold();
        test_n64();
        test_display("n64", 1'b1, 7'h0E, 7'h30, 7'h40, 7'h19);
        test_reset_midscan();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule

`default_nettype wire
